gate_sweep_checker: RTL and testbench

- Stimulus/response end of the basic-gates interface: drives a 2-bit operand pair (a, b) into a gates unit and checks the 3-bit result y = {a&b, a|b, ~a}.
- Sweeps all four input combinations in order 00, 01, 10, 11. Holds each combination for a fixed number of cycles, samples y, and records mismatches.
- Replaces hand-written testbench stimulus on lab boards and in integration sims; sits beside the gates unit with its a/b outputs wired to the gate inputs and y wired back.

---
 rtl/gate_sweep_checker_pkg.sv | 19 +
 rtl/gate_sweep_checker_if.sv | 12 +
 rtl/gate_sweep_checker_ref_model.sv | 16 +
 rtl/gate_sweep_checker.sv | 124 ++++++++++++
 tb/tb_gate_sweep_checker.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/gate_sweep_checker_pkg.sv
// Shared definitions for the gate sweep checker.
//   state_t      : checker FSM states
//   NUM_COMBOS   : number of {a,b} operand combinations swept
//   gate_expect  : golden result {a&b, a|b, ~a} for one operand pair
package gate_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_COMBOS = 4;

    function automatic logic [2:0] gate_expect(input logic a, input logic b);
        return {a & b, a | b, ~a};
    endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Operand/result bus between the sweep checker and the gates unit.
//   a_out, b_out : operands driven by the checker
//   y_in         : gates unit result, [2]=AND, [1]=OR, [0]=NOT a
// master = checker side, slave = gates unit side.
interface gate_sweep_checker_if;
    logic       a_out;
    logic       b_out;
    logic [2:0] y_in;

    modport master (output a_out, output b_out, input  y_in);
    modport slave  (input  a_out, input  b_out, output y_in);
endinterface

// File: rtl/gate_sweep_checker_ref_model.sv
// Combinational expected-result generator for the gates unit.
//   a, b  : operands currently driven
//   y_exp : expected gates unit result
// Kept separate so the checker FSM carries no gate logic and this block can
// be replaced when the gates unit grows outputs.
module gate_ref_model
    import gate_pkg::*;
(
    input  logic       a,
    input  logic       b,
    output logic [2:0] y_exp
);

    assign y_exp = gate_expect(a, b);

endmodule

// File: rtl/gate_sweep_checker.sv
// Stimulus/response checker for the basic-gates unit. On start it drives
// {a,b} = 00, 01, 10, 11, holding each for HOLD_CYCLES cycles, samples y at
// the end of each hold and records which combinations mismatched.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a sweep (honoured in IDLE or DONE only)
//   gates      : operand/result bus to the gates unit (master side)
//   busy       : sweep in progress
//   done       : sweep finished (level until next start or rst)
//   pass       : done with no mismatches
//   err_count  : number of failing combinations (0..4)
//   fail_vec   : bit k set when combination {a,b}=k mismatched
//   last_y     : most recently sampled y
module gate_sweep_checker
    import gate_pkg::*;
#(
    parameter int HOLD_CYCLES = 50
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    gate_sweep_checker_if.master        gates,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [2:0]                  err_count,
    output logic [NUM_COMBOS-1:0]       fail_vec,
    output logic [2:0]                  last_y
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             a_q, b_q;
    logic [2:0]       y_exp;

    logic             start_sweep;
    logic             sample;
    logic             mismatch;
    logic             last_combo;

    gate_ref_model u_ref (
        .a     (a_q),
        .b     (b_q),
        .y_exp (y_exp)
    );

    assign gates.a_out = a_q;
    assign gates.b_out = b_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DRIVE;
            DRIVE:   if (sample && last_combo) state_d = DONE;
            DONE:    if (start) state_d = DRIVE;
            default: state_d = IDLE;
        endcase
    end

    // Decode: the combination index is the operand pair itself, so {a_q,b_q}
    // doubles as the sweep position while in DRIVE.
    always_comb begin
        start_sweep = ((state_q == IDLE) || (state_q == DONE)) && start;
        sample      = (state_q == DRIVE) && (cnt_q == HOLD_LAST);
        mismatch    = sample && (gates.y_in != y_exp);
        last_combo  = ({a_q, b_q} == 2'(NUM_COMBOS - 1));
    end

    // Registered outputs and sweep datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
            last_y    <= '0;
        end else if (start_sweep) begin
            cnt_q     <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
            last_y    <= '0;
        end else if (state_q == DRIVE) begin
            if (sample) begin
                last_y <= gates.y_in;
                if (mismatch) begin
                    fail_vec[{a_q, b_q}] <= 1'b1;
                    err_count            <= err_count + 3'd1;
                end
                if (last_combo) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    // Final sample may itself be the first failure.
                    pass <= (err_count == 3'd0) && !mismatch;
                    a_q  <= 1'b0;
                    b_q  <= 1'b0;
                end else begin
                    {a_q, b_q} <= {a_q, b_q} + 2'd1;
                    cnt_q      <= '0;
                end
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
module tb_gate_sweep_checker;
    import gate_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    // Gates unit behaviour: 0 correct, 1 AND stuck-at-0, 2 NOT replaced by a,
    // 3 per-combination random corruption from tbl.
    int               mode;
    logic [3:0][2:0]  tbl;

    function automatic logic [2:0] exp_y(input logic [1:0] k);
        logic a, b;
        a = k[1];
        b = k[0];
        return {a & b, a | b, ~a};
    endfunction

    function automatic logic [2:0] gates_fn(input logic [1:0] k, input int md,
                                            input logic [3:0][2:0] t);
        logic [2:0] c;
        c = exp_y(k);
        case (md)
            1:       return c & 3'b011;
            2:       return {c[2:1], k[1]};
            3:       return c ^ t[k];
            default: return c;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Two checkers: index 0 with HOLD_CYCLES=50, index 1 with HOLD_CYCLES=1.
    gate_sweep_checker_if gif50 ();
    gate_sweep_checker_if gif1 ();
    assign gif50.y_in = gates_fn({gif50.a_out, gif50.b_out}, mode, tbl);
    assign gif1.y_in  = gates_fn({gif1.a_out, gif1.b_out}, mode, tbl);

    logic [1:0]       d_busy, d_done, d_pass;
    logic [1:0][2:0]  d_err, d_last;
    logic [1:0][3:0]  d_fail;
    logic [1:0][1:0]  d_ab;
    assign d_ab[0] = {gif50.a_out, gif50.b_out};
    assign d_ab[1] = {gif1.a_out, gif1.b_out};

    gate_sweep_checker #(.HOLD_CYCLES(50)) dut50 (
        .clk(clk), .rst(rst), .start(start), .gates(gif50),
        .busy(d_busy[0]), .done(d_done[0]), .pass(d_pass[0]),
        .err_count(d_err[0]), .fail_vec(d_fail[0]), .last_y(d_last[0])
    );

    gate_sweep_checker #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .gates(gif1),
        .busy(d_busy[1]), .done(d_done[1]), .pass(d_pass[1]),
        .err_count(d_err[1]), .fail_vec(d_fail[1]), .last_y(d_last[1])
    );

    // Behavioural model: a sweep is a single elapsed-cycle count ph since the
    // start edge; combination ph/H is on the bus and every H cycles one
    // combination is judged.
    int               hold [2] = '{50, 1};
    int               ph   [2];
    logic [1:0]       m_busy, m_done, m_pass;
    logic [1:0][2:0]  m_err, m_last;
    logic [1:0][3:0]  m_fail;
    logic [1:0][1:0]  m_ab;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int         k;
            logic [2:0] y;
            if (rst) begin
                ph[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0;
                m_err[i] = 0; m_last[i] = 0; m_fail[i] = 0; m_ab[i] = 0;
            end else if (!m_busy[i] && start) begin
                ph[i] = 0; m_busy[i] = 1; m_done[i] = 0; m_pass[i] = 0;
                m_err[i] = 0; m_last[i] = 0; m_fail[i] = 0; m_ab[i] = 0;
            end else if (m_busy[i]) begin
                ph[i] = ph[i] + 1;
                if (ph[i] % hold[i] == 0) begin
                    k = ph[i] / hold[i] - 1;
                    y = gates_fn(2'(k), mode, tbl);
                    m_last[i] = y;
                    if (y !== exp_y(2'(k))) begin
                        m_fail[i][k] = 1'b1;
                        m_err[i] = m_err[i] + 3'd1;
                    end
                    if (k == 3) begin
                        m_busy[i] = 0; m_done[i] = 1; m_ab[i] = 0;
                        m_pass[i] = (m_err[i] == 0);
                    end else begin
                        m_ab[i] = 2'(k + 1);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("busy%0d", i), 32'(d_busy[i]), 32'(m_busy[i]));
                check($sformatf("done%0d", i), 32'(d_done[i]), 32'(m_done[i]));
                check($sformatf("pass%0d", i), 32'(d_pass[i]), 32'(m_pass[i]));
                check($sformatf("err%0d", i),  32'(d_err[i]),  32'(m_err[i]));
                check($sformatf("fail%0d", i), 32'(d_fail[i]), 32'(m_fail[i]));
                check($sformatf("last%0d", i), 32'(d_last[i]), 32'(m_last[i]));
                check($sformatf("ab%0d", i),   32'(d_ab[i]),   32'(m_ab[i]));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done50(output int n);
        n = 0;
        while (!d_done[0] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("done50_wait", 32'(d_done[0]), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; mode = 0; tbl = '0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("rst_busy", 32'(d_busy[0]), 32'd0);
        check("rst_done", 32'(d_done[0]), 32'd0);
        check("rst_ab",   32'(d_ab[0]),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Correct unit, start re-pulsed at cycle 75 (ignored by the 50-cycle checker)
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!d_done[0] && n < 300) begin
            @(negedge clk);
            n++;
            start = (n == 75);
        end
        start = 1'b0;
        check("done_latency50", 32'(n), 32'd200);
        check("pass_ok",  32'(d_pass[0]), 32'd1);
        check("err_ok",   32'(d_err[0]),  32'd0);
        check("fail_ok",  32'(d_fail[0]), 32'h0);
        check("last_ok",  32'(d_last[0]), 32'b110);
        check("pass1_ok", 32'(d_pass[1]), 32'd1);

        // HOLD_CYCLES=1: one cycle per combination, done 4 cycles after start
        pulse_start();
        for (int j = 0; j < 4; j++) begin
            check("h1_ab", 32'(d_ab[1]), 32'(j));
            check("h1_busy", 32'(d_busy[1]), 32'd1);
            @(negedge clk);
        end
        check("h1_done", 32'(d_done[1]), 32'd1);
        check("h1_pass", 32'(d_pass[1]), 32'd1);
        wait_done50(n);

        // AND output stuck at 0
        mode = 1;
        pulse_start();
        wait_done50(n);
        check("sa0_fail", 32'(d_fail[0]), 32'b1000);
        check("sa0_err",  32'(d_err[0]),  32'd1);
        check("sa0_pass", 32'(d_pass[0]), 32'd0);
        check("sa0_last", 32'(d_last[0]), 32'b010);

        // NOT output replaced by a
        mode = 2;
        pulse_start();
        wait_done50(n);
        check("inv_fail", 32'(d_fail[0]), 32'b1111);
        check("inv_err",  32'(d_err[0]),  32'd4);
        check("inv_pass", 32'(d_pass[0]), 32'd0);
        check("inv_last", 32'(d_last[0]), 32'b111);

        // Reset mid-sweep after two failures recorded
        pulse_start();
        repeat (119) @(negedge clk);
        check("mid_err", 32'(d_err[0]), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(d_busy[0]), 32'd0);
        check("abort_err",  32'(d_err[0]),  32'd0);
        check("abort_fail", 32'(d_fail[0]), 32'h0);
        check("abort_last", 32'(d_last[0]), 32'h0);
        mode = 0;
        pulse_start();
        wait_done50(n);
        check("clean_latency", 32'(n), 32'd200);
        check("clean_pass", 32'(d_pass[0]), 32'd1);

        // Randomized gates faults, start pulses and occasional resets
        repeat (25) begin
            mode = int'($urandom_range(0, 3));
            for (int j = 0; j < 4; j++) tbl[j] = 3'($urandom_range(0, 7));
            repeat ($urandom_range(20, 260)) begin
                start = ($urandom_range(0, 19) == 0);
                rst   = ($urandom_range(0, 299) == 0);
                @(negedge clk);
            end
        end
        start = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
